// File: rtl/pipelined_carry_bypass_adder.sv
// Pipelined carry-bypass add/subtract unit: the W-bit carry chain is split into STAGES
// register-separated segments of N-bit bypass blocks, with a valid/ready stream handshake.
module pipelined_carry_bypass_adder #(
  parameter int W      = 32,
  parameter int N      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int SEG  = W / STAGES;
  localparam int NBLK = SEG / N;

  // One segment: ripple inside each N-bit block, block carry skips the ripple when all bits propagate.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                           input logic ci);
    logic [SEG-1:0] s;
    logic c, cb, p, g, pall;
    s = '0;
    c = ci;
    for (int blk = 0; blk < NBLK; blk++) begin
      cb   = c;
      pall = 1'b1;
      for (int i = 0; i < N; i++) begin
        p                = x[blk*N+i] ^ y[blk*N+i];
        g                = x[blk*N+i] & y[blk*N+i];
        s[blk*N+i]       = p ^ cb;
        cb               = g | (p & cb);
        pall             = pall & p;
      end
      c = pall ? c : cb;
    end
    return {c, s};
  endfunction

  logic         advance;
  logic [W-1:0] a_st   [STAGES];
  logic [W-1:0] b_st   [STAGES];
  logic [W-1:0] s_st   [STAGES];
  logic [W-1:0] s_nxt  [STAGES];
  logic         c_st   [STAGES];
  logic         c_nxt  [STAGES];
  logic         vld_st [STAGES];
  logic         ovf_nxt;

  logic [W-1:0] a_p    [STAGES];
  logic [W-1:0] b_p    [STAGES];
  logic [W-1:0] s_p    [STAGES];
  logic         c_p    [STAGES];
  logic         vld_p  [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    logic [SEG:0] r;
    r = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_st[k]   = a;
        b_st[k]   = sub ? ~b : b;
        s_st[k]   = '0;
        c_st[k]   = sub | cin;
        vld_st[k] = in_valid;
      end else begin
        a_st[k]   = a_p[k];
        b_st[k]   = b_p[k];
        s_st[k]   = s_p[k];
        c_st[k]   = c_p[k];
        vld_st[k] = vld_p[k];
      end
      r                          = seg_add(a_st[k][k*SEG +: SEG], b_st[k][k*SEG +: SEG], c_st[k]);
      s_nxt[k]                   = s_st[k];
      s_nxt[k][k*SEG +: SEG]     = r[SEG-1:0];
      c_nxt[k]                   = r[SEG];
    end
    // Carry into the MSB recovered from its sum bit, then compared with the final carry.
    ovf_nxt = c_nxt[STAGES-1] ^ s_nxt[STAGES-1][W-1] ^ a_st[STAGES-1][W-1] ^ b_st[STAGES-1][W-1];
  end

  // Inter-stage data registers: operands skew along with the pipe, finished sum bits deskew.
  always_ff @(posedge clk) begin
    for (int k = 1; k < STAGES; k++) begin
      if (advance && vld_st[k-1]) begin
        a_p[k] <= a_st[k-1];
        b_p[k] <= b_st[k-1];
        s_p[k] <= s_nxt[k-1];
        c_p[k] <= c_nxt[k-1];
      end
    end
  end

  // Stage valids and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < STAGES; k++) vld_p[k] <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_st[k-1];
      out_valid <= vld_st[STAGES-1];
      if (vld_st[STAGES-1]) begin
        sum  <= s_nxt[STAGES-1];
        cout <= c_nxt[STAGES-1];
        ovf  <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// Directed and streamed checks of pipelined_carry_bypass_adder at W=32, N=4, STAGES=2.
module tb_pipelined_carry_bypass_adder;
  localparam int W = 32;
  localparam int N = 4;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  pipelined_carry_bypass_adder #(.W(W), .N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   r;
    yy = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb | ci)};
    return {(x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]), r[W], r[W-1:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb;
  endtask

  logic [W+1:0] exp_q[$];
  logic [W+1:0] held, e;
  logic         stalled;
  int           sent, rcvd;

  initial begin
    tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4]  = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[5]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[8]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tbl[9]  = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tbl[10] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    tbl[11] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    tbl[12] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 32'h7777_7788, 1'b0, 1'b0};
    tbl[13] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

    in_valid = 1'b0; out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", {28'd0, in_ready, out_valid, ovf, cout, sum}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    rst_n = 1'b1;

    // Single beats from the table, inputs scrambled once accepted.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      drive($urandom, $urandom, 1'($urandom), 1'($urandom));
      repeat (STAGES - 1) @(negedge clk);
      #1;
      chk($sformatf("vec%0d", i), {29'd0, out_valid, ovf, cout, sum},
          {29'd0, 1'b1, tbl[i].ovf, tbl[i].cout, tbl[i].sum});
    end
    @(negedge clk);
    #1;
    chk("bubble_hold", {29'd0, out_valid, ovf, cout, sum},
        {29'd0, 1'b0, tbl[13].ovf, tbl[13].cout, tbl[13].sum});

    // Full-rate burst: four back-to-back beats leave on consecutive cycles.
    exp_q.delete();
    for (int j = 0; j < 4 + STAGES; j++) begin
      @(negedge clk);
      if (j < 4) begin
        drive($urandom, $urandom, 1'($urandom), 1'($urandom));
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, cin, sub));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (j >= STAGES) begin
        e = exp_q.pop_front();
        chk($sformatf("burst%0d", j - STAGES), {29'd0, out_valid, ovf, cout, sum}, {29'd0, 1'b1, e});
      end
    end

    // Stream with out_ready toggling and random in_valid.
    exp_q.delete();
    sent = 0; rcvd = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 400 && rcvd < 16; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 16) && ($urandom_range(0, 1) == 1);
      drive($urandom, $urandom, 1'($urandom), 1'($urandom));
      #1;
      if (stalled)
        chk("stall_hold", {29'd0, out_valid, ovf, cout, sum}, {29'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stream_extra: got unexpected beat sum=%h expected none", sum);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("stream%0d", rcvd), {30'd0, ovf, cout, sum}, {30'd0, e});
        end
        rcvd++;
      end
      stalled = out_valid && !out_ready;
      held    = {ovf, cout, sum};
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", {32'(rcvd), 32'(exp_q.size())}, {32'd16, 32'd0});

    // Reset with beats in flight.
    @(negedge clk);
    drive(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    drive(32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_reset", {29'd0, out_valid, ovf, cout, sum}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h30});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {29'd0, out_valid, ovf, cout, sum}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("no_stale%0d", j), {31'd0, out_valid, sum}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
